sar_seq_ctrl: RTL and testbench

SAR_SEQ_CTRL -- requirements
Module: sar_seq_ctrl

---
 rtl/sar_seq_pkg.sv | 17 +
 rtl/sar_core.sv | 37 +++
 rtl/sar_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sar_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_seq_pkg.sv
// Shared definitions for the SAR sequencer: FSM state type and channel-index width helper.
package sar_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SAMPLE,
        ST_CONV,
        ST_DONE
    } state_t;

    // Channel index width: max(1, clog2(n)).
    function automatic int unsigned chw_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_core.sv
// Successive-approximation bit-search register: MSB-first trial bits, one bit resolved per step.
module sar_core #(
    parameter int unsigned SIZE = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            load,
    input  logic            step,
    input  logic            cmp,
    output logic [SIZE-1:0] result,
    output logic            last
);

    localparam logic [SIZE-1:0] MSB = {1'b1, {(SIZE-1){1'b0}}};

    // One-hot marker of the bit currently under test.
    logic [SIZE-1:0] trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            trial  <= '0;
        end else if (en) begin
            if (load) begin
                result <= MSB;
                trial  <= MSB;
            end else if (step) begin
                result <= (cmp ? result : (result & ~trial)) | (trial >> 1);
                trial  <= trial >> 1;
            end
        end
    end

    assign last = trial[0];

endmodule

// File: rtl/sar_seq_ctrl.sv
// Multi-channel SAR ADC sequencer with result handshake.
// Optional 4x averaging per channel when SAR_SEQ_AVG_EN is defined.
module sar_seq_ctrl
    import sar_seq_pkg::*;
#(
    parameter  int unsigned SIZE = 10,
    parameter  int unsigned NCH  = 8,
    localparam int unsigned CHW  = chw_of(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            soc,
    input  logic            cont,
    input  logic [NCH-1:0]  ch_mask,
    input  logic [3:0]      swidth,
    input  logic            cmp,
    output logic            sample_n,
    output logic            dac_rst,
    output logic [CHW-1:0]  mux_sel,
    output logic [SIZE-1:0] data,
    output logic [CHW-1:0]  data_ch,
    output logic            data_valid,
    input  logic            data_ready,
    output logic            eoc,
    output logic            busy
);

    state_t          state;
    logic [NCH-1:0]  mask_q;
    logic [3:0]      scnt;
    logic [SIZE-1:0] result;
    logic            core_last;

    logic            first_found;
    logic [CHW-1:0]  first_idx;
    logic            nxt_found;
    logic [CHW-1:0]  nxt_idx;

`ifdef SAR_SEQ_AVG_EN
    logic [1:0]      pass;
    logic [SIZE+1:0] acc;
    logic [SIZE+1:0] sum;

    assign sum = acc + (SIZE+2)'(result);
`endif

    sar_core #(
        .SIZE (SIZE)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .load   (state == ST_SEL),
        .step   (state == ST_CONV),
        .cmp    (cmp),
        .result (result),
        .last   (core_last)
    );

    // Lowest set channel of the live mask, and next masked channel above the current one.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        nxt_found   = 1'b0;
        nxt_idx     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_mask[i] && !first_found) begin
                first_found = 1'b1;
                first_idx   = CHW'(i);
            end
            if (mask_q[i] && (i > 32'(mux_sel)) && !nxt_found) begin
                nxt_found = 1'b1;
                nxt_idx   = CHW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mask_q     <= '0;
            scnt       <= '0;
            mux_sel    <= '0;
            data       <= '0;
            data_ch    <= '0;
            data_valid <= 1'b0;
            eoc        <= 1'b0;
            busy       <= 1'b0;
            dac_rst    <= 1'b0;
            sample_n   <= 1'b1;
`ifdef SAR_SEQ_AVG_EN
            pass       <= '0;
            acc        <= '0;
`endif
        end else if (en) begin
            eoc     <= 1'b0;
            dac_rst <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (soc && first_found) begin
                        state   <= ST_SEL;
                        mask_q  <= ch_mask;
                        mux_sel <= first_idx;
                        dac_rst <= 1'b1;
                        busy    <= 1'b1;
`ifdef SAR_SEQ_AVG_EN
                        pass    <= '0;
`endif
                    end
                end
                ST_SEL: begin
                    state    <= ST_SAMPLE;
                    sample_n <= 1'b0;
                    scnt     <= '0;
`ifdef SAR_SEQ_AVG_EN
                    // The core still holds the previous pass's final value here.
                    acc      <= (pass == 2'd0) ? '0 : sum;
`endif
                end
                ST_SAMPLE: begin
                    if (scnt == swidth) begin
                        state    <= ST_CONV;
                        sample_n <= 1'b1;
                    end else begin
                        scnt <= scnt + 4'd1;
                    end
                end
                ST_CONV: begin
                    if (core_last) begin
`ifdef SAR_SEQ_AVG_EN
                        if (pass != 2'd3) begin
                            pass    <= pass + 2'd1;
                            state   <= ST_SEL;
                            dac_rst <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
`else
                        state <= ST_DONE;
`endif
                    end
                end
                ST_DONE: begin
                    if (!data_valid || data_ready) begin
`ifdef SAR_SEQ_AVG_EN
                        data    <= sum[SIZE+1:2];
                        pass    <= '0;
`else
                        data    <= result;
`endif
                        data_ch    <= mux_sel;
                        data_valid <= 1'b1;
                        if (nxt_found) begin
                            state   <= ST_SEL;
                            mux_sel <= nxt_idx;
                            dac_rst <= 1'b1;
                        end else if (cont && first_found) begin
                            state   <= ST_SEL;
                            mask_q  <= ch_mask;
                            mux_sel <= first_idx;
                            dac_rst <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            eoc   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench for sar_seq_ctrl: behavioural comparator/SAR model and expected-result queues.
// Honours SAR_SEQ_AVG_EN to expect averaged results and latency.
module tb_sar_seq_ctrl;
    import sar_seq_pkg::*;

    localparam int unsigned SIZE = 10;
    localparam int unsigned NCH  = 8;
    localparam int unsigned CHW  = chw_of(NCH);
`ifdef SAR_SEQ_AVG_EN
    localparam int NPASS = 4;
`else
    localparam int NPASS = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n, en, soc, cont, cmp, data_ready;
    logic [NCH-1:0]  ch_mask;
    logic [3:0]      swidth;
    logic            sample_n, dac_rst, data_valid, eoc, busy;
    logic [CHW-1:0]  mux_sel, data_ch;
    logic [SIZE-1:0] data;

    sar_seq_ctrl #(.SIZE(SIZE), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .soc(soc), .cont(cont),
        .ch_mask(ch_mask), .swidth(swidth), .cmp(cmp),
        .sample_n(sample_n), .dac_rst(dac_rst), .mux_sel(mux_sel),
        .data(data), .data_ch(data_ch), .data_valid(data_valid),
        .data_ready(data_ready), .eoc(eoc), .busy(busy)
    );

    always #5 clk = ~clk;

    int vin [NCH];
    int checks = 0;
    int errors = 0;
    int got_d[$], got_ch[$], exp_d[$], exp_ch[$];
    int eoc_cnt = 0;
    bit rnd_ready = 0, rnd_en = 0, rnd_soc = 0;

    // Analog side: comparator against the channel voltage, plus result/eoc observers.
    bit seen = 0;
    int k = 0, approx = 0, conv_idx = 0, target, trial;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0; k = 0; approx = 0; conv_idx = 0; cmp = 1'b0;
        end else if (en) begin
            if (!sample_n) begin
                seen = 1; k = 0; approx = 0;
            end else if (seen) begin
                target = vin[mux_sel] + ((NPASS > 1) ? (conv_idx % NPASS) : 0);
                trial  = approx | (1 << (SIZE - 1 - k));
                cmp    = (trial <= target);
                if (cmp) approx = trial;
                k++;
                if (k == SIZE) begin
                    seen = 0;
                    conv_idx++;
                end
            end
            if (data_valid && data_ready) begin
                got_d.push_back(int'(data));
                got_ch.push_back(int'(data_ch));
            end
            if (eoc) eoc_cnt++;
        end
    end

    function automatic int exp_val(input int ch);
        int s = 0;
        for (int p = 0; p < NPASS; p++) s += vin[ch] + ((NPASS > 1) ? p : 0);
        return s / NPASS;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) data_ready = ($urandom % 2) != 0;
        if (rnd_en)    en = ($urandom % 4) != 0;
        if (rnd_soc)   soc = busy && (($urandom % 3) == 0);
    endtask

    task automatic expect_mask(input logic [NCH-1:0] m, input int reps);
        for (int r = 0; r < reps; r++)
            for (int ch = 0; ch < NCH; ch++)
                if (m[ch]) begin
                    exp_ch.push_back(ch);
                    exp_d.push_back(exp_val(ch));
                end
    endtask

    task automatic start(input logic [NCH-1:0] m);
        ch_mask = m;
        soc = 1'b1;
        tick();
        soc = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int b = 0;
        while (got_d.size() < n && b < 8000) begin
            tick();
            b++;
        end
        check("result_count_reached", got_d.size(), n);
    endtask

    task automatic wait_idle();
        int b = 0;
        rnd_ready = 0; rnd_en = 0; rnd_soc = 0;
        en = 1'b1; data_ready = 1'b1; soc = 1'b0;
        while (busy !== 1'b0 && b < 8000) begin
            tick();
            b++;
        end
        tick();
        check("idle_busy", busy, 0);
    endtask

    task automatic compare(input string tag);
        check($sformatf("%s_count", tag), got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check($sformatf("%s_ch%0d", tag, i), got_ch[i], exp_ch[i]);
            check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
        end
        got_d.delete(); got_ch.delete(); exp_d.delete(); exp_ch.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, data, 0);
        check({tag, "_data_ch"}, data_ch, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_eoc"}, eoc, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dac_rst"}, dac_rst, 0);
        check({tag, "_sample_n"}, sample_n, 1);
        check({tag, "_mux_sel"}, mux_sel, 0);
    endtask

    initial begin
        int lat, nlow, b;
        logic [SIZE-1:0] cap_d;
        logic [CHW-1:0]  cap_ch;
        logic [NCH-1:0]  m;

        rst_n = 1'b0; en = 1'b1; soc = 1'b0; cont = 1'b0; ch_mask = '0;
        swidth = 4'd3; data_ready = 1'b1;
        for (int i = 0; i < NCH; i++) vin[i] = $urandom_range(0, (1 << SIZE) - 4);
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // soc with an empty mask does nothing
        start('0);
        repeat (4) tick();
        check("empty_mask_busy", busy, 0);
        check("empty_mask_dac_rst", dac_rst, 0);

        // Single channel, known input, latency measured from SEL entry
`ifdef SAR_SEQ_AVG_EN
        vin[0] = 'h100;
`else
        vin[0] = 'h2A5;
`endif
        start(8'h01);
        check("sel_dac_rst", dac_rst, 1);
        check("sel_busy", busy, 1);
        check("sel_mux", mux_sel, 0);
        lat = 0; nlow = 0;
        while (data_valid !== 1'b1 && lat < 2000) begin
            tick();
            lat++;
            if (sample_n === 1'b0) nlow++;
        end
        check("latency", lat, (NPASS > 1) ? 4 * (3 + SIZE + 2) + 1 : 3 + SIZE + 3);
        check("sample_cycles", nlow, NPASS * 4);
`ifdef SAR_SEQ_AVG_EN
        check("single_data", data, 'h101);
`else
        check("single_data", data, 'h2A5);
`endif
        check("single_ch", data_ch, 0);
        check("single_eoc", eoc, 1);
        tick();
        check("single_eoc_pulse", eoc, 0);
        check("single_busy", busy, 0);
        check("single_eoc_cnt", eoc_cnt, 1);
        got_d.delete(); got_ch.delete(); eoc_cnt = 0;

        // Sparse mask: 2, 5, 7 in order then one eoc
        swidth = 4'd2;
        start(8'hA4);
        expect_mask(8'hA4, 1);
        wait_results(3);
        wait_idle();
        check("a4_eoc_cnt", eoc_cnt, 1);
        compare("a4");
        eoc_cnt = 0;

        // Backpressure: result held stable while data_ready is low
        data_ready = 1'b0;
        swidth = 4'd5;
        start(8'h06);
        expect_mask(8'h06, 1);
        b = 0;
        while (data_valid !== 1'b1 && b < 2000) begin
            tick();
            b++;
        end
        check("bp_valid", data_valid, 1);
        cap_d = data; cap_ch = data_ch;
        check("bp_first_ch", cap_ch, 1);
        check("bp_first_data", cap_d, exp_val(1));
        for (int i = 0; i < 40; i++) begin
            tick();
            check("bp_hold_valid", data_valid, 1);
            check("bp_hold_data", data, cap_d);
            check("bp_hold_ch", data_ch, cap_ch);
        end
        check("bp_busy", busy, 1);
        data_ready = 1'b1;
        wait_results(2);
        wait_idle();
        compare("bp");
        eoc_cnt = 0;

        // Continuous mode, stopped during the third sequence
        swidth = 4'd1;
        cont = 1'b1;
        start(8'h03);
        expect_mask(8'h03, 3);
        wait_results(5);
        cont = 1'b0;
        wait_results(6);
        wait_idle();
        repeat (30) tick();
        check("cont_eoc_cnt", eoc_cnt, 1);
        compare("cont");
        eoc_cnt = 0;

        // Reset in the middle of a conversion, then a fresh sequence
        swidth = 4'd4;
        start(8'hFF);
        b = 0;
        while (sample_n !== 1'b0 && b < 200) begin tick(); b++; end
        while (sample_n !== 1'b1 && b < 400) begin tick(); b++; end
        check("midconv_reached", sample_n, 1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midconv_rst");
        tick();
        rst_n = 1'b1;
        got_d.delete(); got_ch.delete(); eoc_cnt = 0;
        tick();
        m = NCH'($urandom_range(1, (1 << NCH) - 1));
        start(m);
        expect_mask(m, 1);
        wait_results($countones(m));
        wait_idle();
        check("post_rst_eoc_cnt", eoc_cnt, 1);
        compare("post_rst");
        eoc_cnt = 0;

        // Randomised sequences with random enable, backpressure and stray soc
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < NCH; i++) vin[i] = $urandom_range(0, (1 << SIZE) - 4);
            swidth = 4'($urandom_range(0, 15));
            m = NCH'($urandom_range(1, (1 << NCH) - 1));
            start(m);
            expect_mask(m, 1);
            rnd_ready = 1; rnd_en = 1; rnd_soc = 1;
            wait_results($countones(m));
            wait_idle();
            repeat (20) tick();
            check($sformatf("rnd%0d_eoc_cnt", it), eoc_cnt, 1);
            compare($sformatf("rnd%0d", it));
            eoc_cnt = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
